// File: rtl/nco_phase_gen.sv
// Burst phase generator feeding the cordic: emits theta_k = phase_off + k*fcw (mod 2^PHASE_W)
// over a valid/ready handshake, holding each sample stable through backpressure.
module nco_phase_gen #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [CNT_W-1:0]   count,
  output logic [PHASE_W-1:0] theta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] theta_q, theta_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic xfer;
  logic last_sample;

  assign xfer        = valid_q && out_ready;
  assign last_sample = (remaining_q == CNT_W'(1));

  // State and registered outputs; reset is synchronous and active-high.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q     <= StIdle;
      theta_q     <= '0;
      fcw_q       <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      theta_q     <= theta_d;
      fcw_q       <= fcw_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (count != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        // Stop wins over completion: an aborted burst never reports done.
        if (stop) begin
          state_d = StIdle;
        end else if (xfer && last_sample) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    theta_d     = theta_q;
    fcw_d       = fcw_q;
    remaining_d = remaining_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          fcw_d       = fcw;
          remaining_d = count;
          if (count != '0) begin
            theta_d = phase_off;
          end
        end
      end
      StRun: begin
        // A transfer coinciding with stop is still consumed.
        if (xfer) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (!last_sample) begin
            theta_d = theta_q + fcw_q;
          end
        end
      end
      default: ;
    endcase

    valid_d = (state_d == StRun);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  assign theta     = theta_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen: randomized bursts and ready patterns checked against
// an arithmetic model of the expected phase sequence.
module tb_nco_phase_gen;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] fcw = '0;
  logic [15:0] phase_off = '0;
  logic [15:0] count = '0;
  logic [15:0] theta;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nco_phase_gen #(.PHASE_W(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .stop      (stop),
    .fcw       (fcw),
    .phase_off (phase_off),
    .count     (count),
    .theta     (theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [15:0] model_theta(input logic [15:0] off, input logic [15:0] f,
                                              input int k);
    longint v;
    v = (longint'(off) + longint'(k) * longint'(f)) % 65536;
    return 16'(v);
  endfunction

  // Runs one burst. mode: 0 ready tied high, 1 cordic-like 18-cycle stall, 2 random ready.
  // stop_at >= 0 aborts when that many transfers are done; stop_coinc makes the stop coincide
  // with a transfer. poke_start fires random start pulses while the burst is active.
  task automatic run_burst(input logic [15:0] f, input logic [15:0] off, input int cnt,
                           input int mode, input int stop_at, input bit stop_coinc,
                           input bit poke_start, output int got);
    int  k = 0;
    int  stall = 0;
    int  cyc = 0;
    int  budget;
    bit  fin = 0;
    bit  aborted = 0;
    bit  r;
    budget = cnt * 25 + 20;
    @(negedge clk);
    fcw = f; phase_off = off; count = 16'(cnt); start = 1'b1; out_ready = 1'b0; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fcw = 16'($urandom); phase_off = 16'($urandom); count = 16'($urandom);
    while (!fin && cyc < budget) begin
      if (aborted) begin
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          $display("FAIL abort_state: valid=%b busy=%b done=%b, want 0/0/0",
                   out_valid, busy, done);
        end else n_pass++;
        stop = 1'b0;
        fin = 1;
      end else begin
        n_total++;
        if (out_valid !== (k < cnt) || done !== (k == cnt) || busy !== 1'b1) begin
          $display("FAIL burst_ctrl k=%0d cnt=%0d: valid=%b done=%b busy=%b, want %b/%b/1",
                   k, cnt, out_valid, done, busy, (k < cnt), (k == cnt));
        end else n_pass++;
        if (out_valid === 1'b1) begin
          n_total++;
          if (theta !== model_theta(off, f, k)) begin
            $display("FAIL theta k=%0d: got %0d, want %0d", k, theta, model_theta(off, f, k));
          end else n_pass++;
        end
        if (done === 1'b1 || k >= cnt) fin = 1;
        case (mode)
          0:       r = 1'b1;
          1:       r = (stall == 0);
          default: r = ($urandom_range(0, 2) != 0);
        endcase
        if (stop_at >= 0 && k == stop_at && out_valid === 1'b1) begin
          r = stop_coinc;
          stop = 1'b1;
          aborted = 1;
          fin = 0;
        end
        out_ready = r;
        start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
        if (out_valid === 1'b1 && r) begin
          k++;
          stall = 18;
        end else if (stall > 0) begin
          stall--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    stop = 1'b0;
    out_ready = 1'b0;
    if (!fin) begin
      n_total++;
      $display("FAIL timeout: burst cnt=%0d stuck after %0d transfers", cnt, k);
    end else if (!aborted) begin
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
        $display("FAIL post_done: busy=%b done=%b valid=%b, want 0/0/0", busy, done, out_valid);
      end else n_pass++;
    end
    got = k;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (theta !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset: theta=%0d valid=%b busy=%b done=%b, want 0/0/0/0",
               theta, out_valid, busy, done);
    end else n_pass++;
    rstb = 1'b0;
  endtask

  task automatic test_basic();
    int got;
    run_burst(16'd500, 16'd0, 4, 0, -1, 1'b0, 1'b0, got);
    n_total++;
    if (got !== 4) $display("FAIL basic_count: got %0d, want 4", got);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int got;
    run_burst(16'd1000, 16'd65000, 3, 0, -1, 1'b0, 1'b0, got);
    n_total++;
    if (got !== 3) $display("FAIL wrap_count: got %0d, want 3", got);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int got;
    run_burst(16'd500, 16'd0, 131, 1, -1, 1'b0, 1'b0, got);
    n_total++;
    if (got !== 131) $display("FAIL bp_count: got %0d, want 131", got);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    int got;
    run_burst(16'd123, 16'd77, 0, 0, -1, 1'b0, 1'b0, got);
    n_total++;
    if (got !== 0) $display("FAIL zero_count: got %0d transfers, want 0", got);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int got;
    for (int i = 0; i < 3; i++) begin
      run_burst(16'd500, 16'd0, 4, 2, -1, 1'b0, 1'b1, got);
      n_total++;
      if (got !== 4) $display("FAIL ignore_start: got %0d, want 4", got);
      else n_pass++;
    end
  endtask

  task automatic test_stop();
    int got;
    run_burst(16'd300, 16'd10, 5, 0, 2, 1'b0, 1'b0, got);
    n_total++;
    if (got !== 2) $display("FAIL stop_count: got %0d, want 2", got);
    else n_pass++;
    run_burst(16'd300, 16'd10, 5, 0, 2, 1'b1, 1'b0, got);
    n_total++;
    if (got !== 3) $display("FAIL stop_coinc_count: got %0d, want 3", got);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL stop_quiet: done=%b valid=%b busy=%b, want 0/0/0", done, out_valid, busy);
      end else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    @(negedge clk);
    fcw = 16'd700; phase_off = 16'd5; count = 16'd5; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    out_ready = 1'b0;
    n_total++;
    if (theta !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_mid: theta=%0d valid=%b busy=%b done=%b, want 0/0/0/0",
               theta, out_valid, busy, done);
    end else n_pass++;
    run_burst(16'd500, 16'd0, 4, 0, -1, 1'b0, 1'b0, got);
    n_total++;
    if (got !== 4) $display("FAIL reset_mid_burst: got %0d, want 4", got);
    else n_pass++;
  endtask

  task automatic test_random();
    int got;
    int c;
    for (int i = 0; i < 8; i++) begin
      c = $urandom_range(1, 40);
      run_burst(16'($urandom), 16'($urandom), c, 2, -1, 1'b0, 1'b0, got);
      n_total++;
      if (got !== c) $display("FAIL random_count: got %0d, want %0d", got, c);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_ignore_start();
    test_stop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
